qreg_uart_tx: RTL
=================

Name: qreg_uart_tx

Overview:
Downstream consumer of the CPU's Q (output) register. Each time the CPU writes Q, the block captures the byte into a small FIFO. It then serialises queued bytes onto a single 8N1 asynchronous serial line. The CPU has no stall input, so the block never back-pressures: it drops bytes on overflow and records the event in a sticky flag.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit (>=1); sim-friendly default
FIFO_DEPTH, 4, byte entries in the capture FIFO; power of two, >=2

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
qLoad  input  1  one-cycle strobe: Q register written this cycle
qData  input  8  value being written to Q (sampled when qLoad=1)
clearOverflow  input  1  synchronous clear of overflow flag
txd  output  1  serial line; idle high
busy  output  1  1 while FIFO non-empty or a frame is in flight
fifoCount  output  $clog2(FIFO_DEPTH)+1  bytes currently queued (excludes the byte being shifted)
overflow  output  1  sticky: a qLoad was dropped because FIFO full

Behaviour:
- Reset (reset=0, async): txd=1, busy=0, fifoCount=0, overflow=0, FSM=IDLE, FIFO pointers=0, bit/clock counters=0.
- Reset mid-frame: txd returns to 1 immediately (asynchronously); queued and in-flight bytes are discarded.
- FIFO push: on a clk edge with qLoad=1, qData is written at the write pointer if fifoCount<FIFO_DEPTH, or if a pop occurs in the same cycle.
- Dropped push: if the FIFO is full and no pop occurs that cycle, the byte is dropped, FIFO contents are unchanged, and overflow is set to 1.
- Pointers wrap modulo FIFO_DEPTH.
- fifoCount changes per edge: +1 on push only, -1 on pop only, unchanged on push+pop.
- Overflow clear: clearOverflow=1 clears overflow on the next edge. If a drop occurs in the same cycle, set wins (overflow=1).
- FSM states:
  - IDLE: txd=1. If fifoCount>0, pop the head into the shift register, go to START, clear the clock counter.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bitIndex=0.
  - DATA: txd=shift[bitIndex], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. At the end, if fifoCount>0, pop and go directly to START (back-to-back, no idle gap); else go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: qLoad at edge N into an empty FIFO/IDLE block gives fifoCount=1 after edge N. The pop happens at edge N+1, so txd falls after edge N+1 and fifoCount returns to 0.
- busy = (FSM!=IDLE) || (fifoCount!=0); registered-equivalent, no combinational path from qLoad.
- txd is driven from a flop (glitch-free).
- A qLoad during any state is accepted subject to FIFO space; the in-flight frame is never disturbed.
- The shift register is loaded only on pop. A later write to Q does not alter the byte in flight.

Test Plan:
- Single byte, CLKS_PER_BIT=4: qLoad with qData=0xA5 while idle. Required: txd held at 0,1,0,1,0,0,1,0,1,1 for 4 cycles each (start, LSB-first data 1,0,1,0,0,1,0,1, stop). busy=1 for 41 cycles from the edge after qLoad. fifoCount pulses 1 for one cycle.
- Back-to-back: qLoad 0x01,0x02,0x03 on consecutive cycles. Required: three frames with no idle cycles between them (120 cycles of activity); fifoCount goes 1,1,2 then decrements at each frame start; decoded bytes are 0x01,0x02,0x03 in order.
- Overflow, FIFO_DEPTH=4: 6 consecutive qLoads 0x10..0x15. Required: the first pops immediately; 0x11..0x14 are queued; 0x15 is dropped and overflow=1. The serial output is 0x10..0x14 only.
- Overflow clear vs set: with the FIFO full, assert clearOverflow and qLoad in the same cycle. Required: overflow stays 1. Then clearOverflow alone gives overflow=0 next cycle.
- Push with pop when full: with the FIFO full and the STOP state ending, qLoad 0x77 in the pop cycle. Required: accepted, fifoCount stays 4, no overflow, and 0x77 is transmitted last.
- Reset mid-frame: drop reset during DATA bit 3 with 2 bytes queued. Required: txd=1 immediately, busy=0, fifoCount=0. After release, a new qLoad 0x3C transmits correctly.

Source files
------------

// File: rtl/qreg_uart_tx.sv
// qreg_uart_tx: captures every CPU write of the Q register into a small FIFO
// and serialises the queued bytes as 8N1 frames on txd. The CPU cannot be
// stalled, so a write into a full FIFO is dropped and flagged in a sticky bit.
module qreg_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          qLoad,
  input  logic [7:0]                    qData,
  input  logic                          clearOverflow,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] clk_cnt, clk_cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift, shift_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, push, drop, bit_last, txd_next;

  assign bit_last = (clk_cnt == CNT_LAST);

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = qLoad && ((fifoCount != DEPTH_FULL) || pop);
  assign drop = qLoad && !push;

  // Derived only from registered state, so qLoad never reaches busy directly.
  assign busy = (state != IDLE) || (fifoCount != '0);

  // Next-state, pop decision and next serial line value.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_idx_next = bit_idx;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        if (fifoCount != '0) begin
          pop          = 1'b1;
          state_next   = START;
          clk_cnt_next = '0;
        end
      end
      START: begin
        if (bit_last) begin
          state_next   = DATA;
          clk_cnt_next = '0;
          bit_idx_next = '0;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_last) begin
          clk_cnt_next = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_last) begin
          clk_cnt_next = '0;
          if (fifoCount != '0) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    shift_next = pop ? mem[rd_ptr] : shift;

    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[bit_idx_next];
      default: txd_next = 1'b1;
    endcase
  end

  // FSM, counters, shift register and registered serial output.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      txd     <= txd_next;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifoCount <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
      if (drop)               overflow <= 1'b1;
      else if (clearOverflow) overflow <= 1'b0;
    end
  end

  // FIFO storage; a slot is only ever read after it has been written.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers and count, which keeps it mappable to plain RAM.
    if (push) mem[wr_ptr] <= qData;
  end

endmodule
